garage_door_actuator: RTL and testbench

GARAGE_DOOR_ACTUATOR -- requirements
Module: garage_door_actuator

---
 rtl/garage_door_actuator.sv | 177 +++++++++++++++++
 tb/tb_garage_door_actuator.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/garage_door_actuator.sv
// -----------------------------------------------------------------------------
// garage_door_actuator
//
// Behavioural actuator model of a garage door: a motor driven by raise/lower
// commands moves a position counter between 0 (closed) and TRAVEL_MAX (open),
// one position step every STEP_DIV clock cycles, and reports the two limit
// switches back to the door controller.
//
// Parameters:
//   POS_W       width of the position counter
//   TRAVEL_MAX  fully-open position (1 .. 2**POS_W-1)
//   STEP_DIV    clock cycles per position step (>= 1)
//
// Ports:
//   CLK      in   rising-edge clock
//   RST      in   asynchronous reset, active low
//   UP_M     in   motor-raise command
//   DN_M     in   motor-lower command
//   UP_Max   out  fully-open limit switch (POS == TRAVEL_MAX)
//   DN_Max   out  fully-closed limit switch (POS == 0)
//   POS      out  current door position, 0 = closed
//   MOVING   out  motor running (raising or lowering)
//   FAULT    out  both commands were seen together; waits for both to drop
//
// Optional build macro OBSTACLE_SENSE_EN adds:
//   OBST     in   obstruction detected under the door
//   BLOCKED  out  lowering is stalled by an obstruction
// -----------------------------------------------------------------------------
module garage_door_actuator #(
   parameter int POS_W      = 8,
   parameter int TRAVEL_MAX = 200,
   parameter int STEP_DIV   = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             UP_M,
   input  logic             DN_M,
`ifdef OBSTACLE_SENSE_EN
   input  logic             OBST,
   output logic             BLOCKED,
`endif
   output logic             UP_Max,
   output logic             DN_Max,
   output logic [POS_W-1:0] POS,
   output logic             MOVING,
   output logic             FAULT
);

   // Prescaler needs at least one bit even when STEP_DIV == 1.
   localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

   localparam logic [PW-1:0]    PRE_LAST = PW'(STEP_DIV - 1);
   localparam logic [PW-1:0]    PRE_ONE  = PW'(1);
   localparam logic [POS_W-1:0] POS_TOP  = POS_W'(TRAVEL_MAX);
   localparam logic [POS_W-1:0] POS_PRE  = POS_W'(TRAVEL_MAX - 1);
   localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);

   typedef enum logic [1:0] {
      ST_STOP,
      ST_RISE,
      ST_FALL,
      ST_FAULT
   } state_t;

   state_t           state_reg, state_next;
   logic [POS_W-1:0] pos_reg, pos_next;
   logic [PW-1:0]    presc_reg, presc_next;

   logic both_cmd;
   logic at_top;
   logic at_bot;
   logic presc_tc;

   assign both_cmd = UP_M & DN_M;
   assign at_top   = (pos_reg == POS_TOP);
   assign at_bot   = (pos_reg == '0);
   assign presc_tc = (presc_reg == PRE_LAST);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_reg <= ST_STOP;
         pos_reg   <= '0;
         presc_reg <= '0;
      end else begin
         state_reg <= state_next;
         pos_reg   <= pos_next;
         presc_reg <= presc_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      pos_next   = pos_reg;
      presc_next = presc_reg;

      // Simultaneous raise+lower outranks everything except an existing fault.
      if (both_cmd && state_reg != ST_FAULT) begin
         state_next = ST_FAULT;
         presc_next = '0;
      end else begin
         case (state_reg)
            ST_STOP: begin
               presc_next = '0;
               if (UP_M && !at_top) begin
                  state_next = ST_RISE;
               end else if (DN_M && !at_bot) begin
                  state_next = ST_FALL;
               end
            end

            ST_RISE: begin
               // Dropping UP_M (including a reversal to DN_M) stops first;
               // the opposite direction can only start from STOP.
               if (!UP_M) begin
                  state_next = ST_STOP;
                  presc_next = '0;
               end else if (presc_tc) begin
                  presc_next = '0;
                  if (!at_top) begin
                     pos_next = pos_reg + POS_ONE;
                  end
                  if (pos_reg >= POS_PRE) begin
                     state_next = ST_STOP;
                  end
               end else begin
                  presc_next = presc_reg + PRE_ONE;
               end
            end

            ST_FALL: begin
               if (!DN_M) begin
                  state_next = ST_STOP;
                  presc_next = '0;
`ifdef OBSTACLE_SENSE_EN
               end else if (OBST) begin
                  // Stall in place; stepping resumes from this prescaler value.
                  presc_next = presc_reg;
`endif
               end else if (presc_tc) begin
                  presc_next = '0;
                  if (!at_bot) begin
                     pos_next = pos_reg - POS_ONE;
                  end
                  if (pos_reg <= POS_ONE) begin
                     state_next = ST_STOP;
                  end
               end else begin
                  presc_next = presc_reg + PRE_ONE;
               end
            end

            ST_FAULT: begin
               if (!UP_M && !DN_M) begin
                  state_next = ST_STOP;
                  presc_next = '0;
               end
            end

            default: begin
               state_next = ST_STOP;
               presc_next = '0;
            end
         endcase
      end
   end

   assign POS    = pos_reg;
   assign UP_Max = at_top;
   assign DN_Max = at_bot;
   assign MOVING = (state_reg == ST_RISE) || (state_reg == ST_FALL);
   assign FAULT  = (state_reg == ST_FAULT);

`ifdef OBSTACLE_SENSE_EN
   assign BLOCKED = (state_reg == ST_FALL) && OBST;
`endif

endmodule

// File: tb/tb_garage_door_actuator.sv
// -----------------------------------------------------------------------------
// tb_garage_door_actuator
//
// Directed scenarios followed by randomized command segments. A reference
// model expressed as "position, direction of travel, cycles into the current
// step, latched fault" predicts every output after every clock edge.
// -----------------------------------------------------------------------------
module tb_garage_door_actuator;

   localparam int POS_W      = 8;
   localparam int TRAVEL_MAX = 200;
   localparam int STEP_DIV   = 4;

   logic             CLK = 1'b0;
   logic             RST = 1'b0;
   logic             UP_M = 1'b0;
   logic             DN_M = 1'b0;
   logic             UP_Max;
   logic             DN_Max;
   logic [POS_W-1:0] POS;
   logic             MOVING;
   logic             FAULT;
`ifdef OBSTACLE_SENSE_EN
   logic             OBST = 1'b0;
   logic             BLOCKED;
`endif

   always #5 CLK = ~CLK;

   garage_door_actuator #(
      .POS_W      (POS_W),
      .TRAVEL_MAX (TRAVEL_MAX),
      .STEP_DIV   (STEP_DIV)
   ) dut (
      .CLK     (CLK),
      .RST     (RST),
      .UP_M    (UP_M),
      .DN_M    (DN_M),
`ifdef OBSTACLE_SENSE_EN
      .OBST    (OBST),
      .BLOCKED (BLOCKED),
`endif
      .UP_Max  (UP_Max),
      .DN_Max  (DN_Max),
      .POS     (POS),
      .MOVING  (MOVING),
      .FAULT   (FAULT)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int m_pos;    // door position
   int m_dir;    // +1 opening, -1 closing, 0 motor off
   int m_cnt;    // cycles spent in the current position step
   bit m_fault;  // conflicting commands seen, waiting for both to drop
   bit m_obst;   // obstruction input seen at the last edge

   function automatic void model_reset();
      m_pos   = 0;
      m_dir   = 0;
      m_cnt   = 0;
      m_fault = 1'b0;
      m_obst  = 1'b0;
   endfunction

   function automatic void model_edge(bit up, bit dn, bit ob);
      m_obst = ob;
      if (m_fault) begin
         if (!up && !dn) m_fault = 1'b0;
      end else if (up && dn) begin
         m_fault = 1'b1;
         m_dir   = 0;
         m_cnt   = 0;
      end else if (m_dir == 0) begin
         m_cnt = 0;
         if (up && m_pos < TRAVEL_MAX) m_dir = 1;
         else if (dn && m_pos > 0)     m_dir = -1;
      end else if ((m_dir > 0 && !up) || (m_dir < 0 && !dn)) begin
         m_dir = 0;
         m_cnt = 0;
      end else if (m_dir < 0 && ob) begin
         // lowering stalled: nothing advances
      end else begin
         m_cnt++;
         if (m_cnt == STEP_DIV) begin
            m_cnt = 0;
            m_pos = m_pos + m_dir;
            if (m_pos == TRAVEL_MAX || m_pos == 0) m_dir = 0;
         end
      end
   endfunction

   task automatic compare_all(input string where);
      check({where, ".pos"},    32'(POS),    32'(m_pos));
      check({where, ".upmax"},  32'(UP_Max), 32'(m_pos == TRAVEL_MAX));
      check({where, ".dnmax"},  32'(DN_Max), 32'(m_pos == 0));
      check({where, ".moving"}, 32'(MOVING), 32'(m_dir != 0));
      check({where, ".fault"},  32'(FAULT),  32'(m_fault));
`ifdef OBSTACLE_SENSE_EN
      check({where, ".blocked"}, 32'(BLOCKED), 32'(m_dir < 0 && m_obst));
`endif
   endtask

   // One clock edge: inputs as set now are what the edge samples.
   task automatic step(input string where);
      bit up, dn, ob;
      up = UP_M;
      dn = DN_M;
      ob = 1'b0;
`ifdef OBSTACLE_SENSE_EN
      ob = OBST;
`endif
      @(posedge CLK);
      #1;
      model_edge(up, dn, ob);
      compare_all(where);
   endtask

   // Keep stepping until the model reaches a target position (bounded).
   task automatic run_until(input string where, input int target);
      int n;
      n = 0;
      while (m_pos != target && n < 3000) begin
         step(where);
         n++;
      end
      check({where, ".reached"}, 32'(m_pos == target), 32'd1);
   endtask

   task automatic async_reset(input string where);
      RST = 1'b0;
      #1;
      model_reset();
      compare_all(where);
      @(negedge CLK);
      RST = 1'b1;
      #1;
      compare_all({where, ".rel"});
   endtask

   initial begin
      model_reset();
      #2;
      compare_all("reset");
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b1;
      #1;
      compare_all("reset_rel");

      // Full opening from closed.
      UP_M = 1'b1;
      step("open");
      check("open.entry_moving", 32'(MOVING), 32'd1);
      repeat (4) step("open");
      check("open.first_step", 32'(POS), 32'd1);
      check("open.dnmax_drop", 32'(DN_Max), 32'd0);
      repeat (796) step("open");
      check("open.top_pos", 32'(POS), 32'(TRAVEL_MAX));
      check("open.top_upmax", 32'(UP_Max), 32'd1);
      check("open.top_stop", 32'(MOVING), 32'd0);

      // Raise request when already fully open.
      UP_M = 1'b0;
      step("top_idle");
      UP_M = 1'b1;
      step("top_pulse");
      check("top_pulse.no_move", 32'(MOVING), 32'd0);
      UP_M = 1'b0;
      step("top_pulse_end");

      // Full closing.
      DN_M = 1'b1;
      repeat (801) step("close");
      check("close.bottom_pos", 32'(POS), 32'd0);
      check("close.bottom_dnmax", 32'(DN_Max), 32'd1);
      step("close_hold");
      check("close.stays_stopped", 32'(MOVING), 32'd0);
      DN_M = 1'b0;
      step("bot_idle");
      DN_M = 1'b1;
      step("bot_pulse");
      check("bot_pulse.no_move", 32'(MOVING), 32'd0);
      DN_M = 1'b0;
      step("bot_pulse_end");

      // Conflicting commands mid-travel.
      UP_M = 1'b1;
      run_until("to37", 37);
      DN_M = 1'b1;
      step("conflict");
      check("conflict.fault", 32'(FAULT), 32'd1);
      check("conflict.pos", 32'(POS), 32'd37);
      UP_M = 1'b0;
      DN_M = 1'b0;
      step("fault_clear");
      check("fault_clear.fault", 32'(FAULT), 32'd0);

      // Asynchronous reset while lowering.
      UP_M = 1'b1;
      run_until("to121", 121);
      UP_M = 1'b0;
      step("pause121");
      DN_M = 1'b1;
      run_until("to120", 120);
      step("mid_fall");
      #2;
      RST = 1'b0;
      #1;
      model_reset();
      check("async.pos", 32'(POS), 32'd0);
      check("async.dnmax", 32'(DN_Max), 32'd1);
      check("async.moving", 32'(MOVING), 32'd0);
      DN_M = 1'b0;
      @(negedge CLK);
      RST = 1'b1;
      #1;
      compare_all("async_rel");

`ifdef OBSTACLE_SENSE_EN
      // Obstruction while lowering.
      UP_M = 1'b1;
      run_until("to60", 60);
      UP_M = 1'b0;
      step("pause60");
      DN_M = 1'b1;
      run_until("to50", 50);
      OBST = 1'b1;
      repeat (10) step("obst");
      check("obst.pos", 32'(POS), 32'd50);
      check("obst.blocked", 32'(BLOCKED), 32'd1);
      OBST = 1'b0;
      run_until("obst_resume", 0);
      DN_M = 1'b0;
      step("obst_done");
`endif

      // Randomized command segments.
      for (int seg = 0; seg < 40; seg++) begin
         int kind;
         int len;
         if ($urandom_range(0, 14) == 0) async_reset("rnd_rst");
         kind = $urandom_range(0, 99);
         len  = $urandom_range(1, 250);
         UP_M = (kind < 40) || (kind >= 80 && kind < 85);
         DN_M = (kind >= 40 && kind < 85);
         for (int c = 0; c < len; c++) begin
`ifdef OBSTACLE_SENSE_EN
            OBST = ($urandom_range(0, 7) == 0);
`endif
            step("rnd");
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
